// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the serial command reader: parser states,
// frame framing constants and the running-checksum helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         FRAME_LEN       = 5;
  localparam int         TIMEOUT_CYC_DEF = 3472;
  localparam int         TO_W_DEF        = 12;

  // Checksum is a plain 8-bit sum that wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] val);
    return acc + val;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_byte_fetch.sv
// Unload handshake toward the UART receiver: one unload strobe per byte,
// data captured the following cycle and presented with a one-cycle valid.
module uart_byte_fetch (
  input  logic       rxclk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       uld_rx_data,
  output logic [7:0] rx_byte,
  output logic       byte_vld
);

  logic       pend_q;
  logic       vld_q;
  logic [7:0] byte_q;
  logic [7:0] byte_d;

  // The cycle after an unload is blocked so the UART can refresh rx_empty.
  assign uld_rx_data = ~rx_empty & ~pend_q;

  always_comb begin
    byte_d = byte_q;
    if (pend_q) begin
      byte_d = rx_data;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      pend_q <= uld_rx_data;
      vld_q  <= pend_q;
      byte_q <= byte_d;
    end
  end

  assign rx_byte  = byte_q;
  assign byte_vld = vld_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Serial command reader: pulls bytes from the UART, parses SYNC/ADDR/DHI/DLO/CSUM
// frames and issues single-cycle write or read-request strobes to the register bank.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int         TO_W        = TO_W_DEF
) (
  input  logic        reset,
  input  logic        rxclk,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        uld_rx_data,
  output logic        cmd_wr,
  output logic        cmd_rd,
  output logic [6:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        busy,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  logic [7:0]    rx_byte;
  logic          byte_vld;

  state_e        state_q, state_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [7:0]    dlo_q, dlo_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]    err_q, err_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [6:0]    caddr_q, caddr_d;
  logic [15:0]   cdata_q, cdata_d;

  logic          to_expire;
  logic          frame_good;
  logic          frame_bad;

  uart_byte_fetch u_fetch (
    .rxclk       (rxclk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .uld_rx_data (uld_rx_data),
    .rx_byte     (rx_byte),
    .byte_vld    (byte_vld)
  );

  // A byte arriving on the last allowed cycle wins over the timeout.
  assign to_expire = (state_q != HUNT) && !byte_vld &&
                     (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (byte_vld) begin
      case (state_q)
        HUNT:    state_d = (rx_byte == SYNC_BYTE) ? ADDR : HUNT;
        ADDR:    state_d = DHI;
        DHI:     state_d = DLO;
        DLO:     state_d = CSUM;
        CSUM:    state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end else if (to_expire) begin
      state_d = HUNT;
    end
  end

  always_comb begin
    busy       = (state_q != HUNT);
    frame_good = byte_vld && (state_q == CSUM) && (rx_byte == csum_q);
    frame_bad  = (byte_vld && (state_q == CSUM) && (rx_byte != csum_q)) || to_expire;
  end

  always_comb begin
    csum_d = csum_q;
    addr_d = addr_q;
    dhi_d  = dhi_q;
    dlo_d  = dlo_q;
    if (byte_vld) begin
      case (state_q)
        HUNT: begin
          if (rx_byte == SYNC_BYTE) begin
            csum_d = 8'h00;
          end
        end
        ADDR: begin
          addr_d = rx_byte;
          csum_d = rx_byte;
        end
        DHI: begin
          dhi_d  = rx_byte;
          csum_d = csum_add(csum_q, rx_byte);
        end
        DLO: begin
          dlo_d  = rx_byte;
          csum_d = csum_add(csum_q, rx_byte);
        end
        default: begin
        end
      endcase
    end
  end

  // The frame timer only runs inside a frame and restarts on every byte.
  always_comb begin
    if ((state_q == HUNT) || byte_vld || to_expire) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_comb begin
    wr_d    = frame_good & ~addr_q[7];
    rd_d    = frame_good &  addr_q[7];
    caddr_d = frame_good ? addr_q[6:0] : caddr_q;
    cdata_d = frame_good ? {dhi_q, dlo_q} : cdata_q;
  end

  // Clearing wins over a same-cycle error; the count sticks at its maximum.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 8'h00;
    end else if (frame_bad && (err_q != 8'hFF)) begin
      err_d = err_q + 8'h01;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      csum_q  <= 8'h00;
      addr_q  <= 8'h00;
      dhi_q   <= 8'h00;
      dlo_q   <= 8'h00;
      to_q    <= '0;
      err_q   <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      caddr_q <= 7'h00;
      cdata_q <= 16'h0000;
    end else begin
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      dhi_q   <= dhi_d;
      dlo_q   <= dlo_d;
      to_q    <= to_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
    end
  end

  assign cmd_wr   = wr_q;
  assign cmd_rd   = rd_q;
  assign cmd_addr = caddr_q;
  assign cmd_data = cdata_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a UART byte source, a frame-level reference model
// checked every cycle, and directed frames with hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int TIMEOUT = 3472;

  logic        rxclk = 1'b0;
  logic        reset;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        err_clr;
  logic        uld_rx_data;
  logic        cmd_wr;
  logic        cmd_rd;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        busy;
  logic [7:0]  err_cnt;

  uart_cmd_parser dut (
    .reset       (reset),
    .rxclk       (rxclk),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .uld_rx_data (uld_rx_data),
    .cmd_wr      (cmd_wr),
    .cmd_rd      (cmd_rd),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .err_cnt     (err_cnt),
    .err_clr     (err_clr)
  );

  always #5 rxclk = ~rxclk;

  int cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // UART holding register model: bytes waiting in fifo, one handed over per unload.
  logic [7:0] fifo[$];
  logic [7:0] stim[$];
  typedef struct {
    int         c;
    logic [7:0] b;
  } vld_t;
  vld_t vldQ[$];
  int popCount = 0;
  int lastPop  = 0;

  always @(posedge rxclk) begin
    #1;
    rx_empty = (fifo.size() == 0);
  end

  // Frame-level reference state
  int          pos = 0;
  int          lastVld = 0;
  logic [7:0]  mAddr = 8'h00, mDhi = 8'h00, mDlo = 8'h00;
  logic [7:0]  expErr = 8'h00;
  logic        expWr = 1'b0, expRd = 1'b0;
  logic [6:0]  expAddr = 7'h00;
  logic [15:0] expData = 16'h0000;
  logic        clrPrev = 1'b0;
  logic        uldPrev = 1'b0;
  int          wrCount = 0;
  int          rdCount = 0;

  always @(negedge rxclk) begin
    vld_t cur;
    logic inc;
    int   sumv;
    inc   = 1'b0;
    expWr = 1'b0;
    expRd = 1'b0;
    if (reset) begin
      vldQ.delete();
      pos     = 0;
      lastVld = cyc;
      expErr  = 8'h00;
      expAddr = 7'h00;
      expData = 16'h0000;
    end else begin
      if (uld_rx_data && (fifo.size() > 0)) begin
        rx_data = fifo.pop_front();
        cur.c = cyc + 2;
        cur.b = rx_data;
        vldQ.push_back(cur);
        popCount++;
        lastPop = cyc;
      end
      if ((vldQ.size() > 0) && (vldQ[0].c == cyc - 1)) begin
        cur = vldQ.pop_front();
        lastVld = cyc - 1;
        case (pos)
          0: if (cur.b == 8'hA5) pos = 1;
          1: begin mAddr = cur.b; pos = 2; end
          2: begin mDhi  = cur.b; pos = 3; end
          3: begin mDlo  = cur.b; pos = 4; end
          default: begin
            sumv = (int'(mAddr) + int'(mDhi) + int'(mDlo)) % 256;
            if (int'(cur.b) == sumv) begin
              expWr   = ~mAddr[7];
              expRd   = mAddr[7];
              expAddr = mAddr[6:0];
              expData = {mDhi, mDlo};
            end else begin
              inc = 1'b1;
            end
            pos = 0;
          end
        endcase
      end else if ((pos != 0) && ((cyc - 1) - lastVld == TIMEOUT)) begin
        pos = 0;
        inc = 1'b1;
      end
      if (clrPrev) expErr = 8'h00;
      else if (inc && (expErr != 8'hFF)) expErr = expErr + 8'h01;
      if (cmd_wr) wrCount++;
      if (cmd_rd) rdCount++;
    end
    checkOutput("model_cmd_wr", 32'(cmd_wr), 32'(expWr));
    checkOutput("model_cmd_rd", 32'(cmd_rd), 32'(expRd));
    checkOutput("model_cmd_addr", 32'(cmd_addr), 32'(expAddr));
    checkOutput("model_cmd_data", 32'(cmd_data), 32'(expData));
    checkOutput("model_busy", 32'(busy), 32'(pos != 0));
    checkOutput("model_err_cnt", 32'(err_cnt), 32'(expErr));
    checkOutput("uld_spacing", 32'(uldPrev & uld_rx_data), 32'd0);
    clrPrev = err_clr;
    uldPrev = uld_rx_data;
  end

  task automatic queueFrame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] e);
    stim.push_back(a);
    stim.push_back(b);
    stim.push_back(c);
    stim.push_back(d);
    stim.push_back(e);
  endtask

  task automatic applyStimulus(input int settle);
    int target;
    int budget;
    int limit;
    target = popCount + stim.size();
    limit  = 4 * stim.size() + 100;
    foreach (stim[i]) fifo.push_back(stim[i]);
    stim.delete();
    budget = 0;
    while ((popCount < target) && (budget < limit)) begin
      @(posedge rxclk); #1;
      budget++;
    end
    if (popCount < target) checkOutput("drain_bytes", popCount, target);
    repeat (settle) begin @(posedge rxclk); #1; end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin @(posedge rxclk); #1; end
  endtask

  initial begin
    int tgt;
    reset   = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge rxclk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_uld", 32'(uld_rx_data), 32'd0);
    checkOutput("reset_err", 32'(err_cnt), 32'd0);
    checkOutput("reset_wr", 32'(cmd_wr), 32'd0);
    reset = 1'b0;
    repeat (2) begin @(posedge rxclk); #1; end

    queueFrame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C);
    applyStimulus(6);
    checkOutput("wr_frame_count", wrCount, 1);
    checkOutput("wr_frame_addr", 32'(cmd_addr), 32'h12);
    checkOutput("wr_frame_data", 32'(cmd_data), 32'h3456);
    checkOutput("wr_frame_err", 32'(err_cnt), 32'd0);

    queueFrame(8'hA5, 8'h92, 8'h00, 8'h01, 8'h93);
    applyStimulus(6);
    checkOutput("rd_frame_count", rdCount, 1);
    checkOutput("rd_frame_no_wr", wrCount, 1);
    checkOutput("rd_frame_addr", 32'(cmd_addr), 32'h12);

    queueFrame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h00);
    applyStimulus(6);
    checkOutput("bad_csum_err", 32'(err_cnt), 32'd1);
    checkOutput("bad_csum_no_wr", wrCount, 1);
    queueFrame(8'hA5, 8'h05, 8'hAB, 8'hCD, 8'h7D);
    applyStimulus(6);
    checkOutput("after_bad_wr", wrCount, 2);
    checkOutput("after_bad_addr", 32'(cmd_addr), 32'h05);
    checkOutput("after_bad_data", 32'(cmd_data), 32'hABCD);

    stim.push_back(8'hFF);
    stim.push_back(8'h00);
    stim.push_back(8'hA5);
    stim.push_back(8'h12);
    applyStimulus(0);
    tgt = lastPop + 2 + TIMEOUT;
    waitUntil(tgt);
    checkOutput("timeout_busy_last_cycle", 32'(busy), 32'd1);
    @(posedge rxclk); #1;
    checkOutput("timeout_busy_after", 32'(busy), 32'd0);
    checkOutput("timeout_err", 32'(err_cnt), 32'd2);
    checkOutput("timeout_no_strobe", wrCount + rdCount, 3);

    queueFrame(8'hA5, 8'hA5, 8'h01, 8'h02, 8'hA8);
    applyStimulus(6);
    checkOutput("sync_as_addr_rd", rdCount, 2);
    checkOutput("sync_as_addr_addr", 32'(cmd_addr), 32'h25);
    checkOutput("sync_as_addr_data", 32'(cmd_data), 32'h0102);

    for (int i = 0; i < 256; i++) queueFrame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00);
    applyStimulus(6);
    checkOutput("err_saturated", 32'(err_cnt), 32'hFF);

    queueFrame(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00);
    applyStimulus(0);
    tgt = lastPop + 2;
    waitUntil(tgt);
    checkOutput("err_before_clr", 32'(err_cnt), 32'hFF);
    err_clr = 1'b1;
    @(posedge rxclk); #1;
    err_clr = 1'b0;
    checkOutput("err_clr_priority", 32'(err_cnt), 32'd0);
    repeat (4) begin @(posedge rxclk); #1; end

    stim.push_back(8'hA5);
    stim.push_back(8'h12);
    stim.push_back(8'h34);
    applyStimulus(3);
    checkOutput("midframe_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge rxclk);
    checkOutput("midframe_reset_busy", 32'(busy), 32'd0);
    checkOutput("midframe_reset_addr", 32'(cmd_addr), 32'h00);
    @(posedge rxclk); #1;
    @(posedge rxclk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge rxclk); #1; end
    queueFrame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C);
    applyStimulus(6);
    checkOutput("post_reset_wr", wrCount, 3);
    checkOutput("post_reset_addr", 32'(cmd_addr), 32'h12);
    checkOutput("post_reset_data", 32'(cmd_data), 32'h3456);
    checkOutput("post_reset_err", 32'(err_cnt), 32'd0);

    repeat (5) begin @(posedge rxclk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
